// File: rtl/intc_irq_arb.sv
// rtl/intc_irq_arb.sv - prioritised interrupt arbiter presenting one request at a time to a CPU
// Four-state flow IDLE -> ARB -> REQ -> GAP; the presented source may be withdrawn or preempted before its ack.
module intc_irq_arb #(
  parameter int NSRC = 16,
  parameter int PW   = 4,
  parameter int IW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   irq_i,
  input  logic [NSRC-1:0]   en_i,
  input  logic [NSRC*PW-1:0] prio_i,
  input  logic [PW-1:0]     mask_i,
  input  logic              ack_i,
  output logic              irq_req_o,
  output logic [PW-1:0]     irq_lvl_o,
  output logic [IW-1:0]     irq_id_o,
  output logic [NSRC-1:0]   ack_src_o
);

  typedef enum logic [1:0] {IDLE, ARB, REQ, GAP} state_t;

  state_t          state, next_state;
  logic [NSRC-1:0] elig;
  logic            any_elig;
  logic [PW-1:0]   best_lvl;
  logic [IW-1:0]   best_id;
  logic            cur_elig;
  logic            preempt;
  logic [NSRC-1:0] ack_onehot;

  // Strict '>' keeps the lowest index on equal priorities.
  always_comb begin
    elig     = '0;
    any_elig = 1'b0;
    best_lvl = '0;
    best_id  = '0;
    cur_elig = 1'b0;
    preempt  = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      elig[k] = irq_i[k] && en_i[k] && (prio_i[k*PW +: PW] > mask_i);
      if (elig[k] && (!any_elig || prio_i[k*PW +: PW] > best_lvl)) begin
        best_lvl = prio_i[k*PW +: PW];
        best_id  = IW'(k);
      end
      any_elig = any_elig | elig[k];
      if (IW'(k) == irq_id_o) begin
        cur_elig = elig[k];
      end else if (elig[k] && prio_i[k*PW +: PW] > irq_lvl_o) begin
        preempt = 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (any_elig) next_state = ARB;
      ARB:  next_state = any_elig ? REQ : IDLE;
      REQ: begin
        if (ack_i)          next_state = GAP;
        else if (!cur_elig) next_state = IDLE;
        else if (preempt)   next_state = ARB;
      end
      GAP:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign ack_onehot = NSRC'(1) << irq_id_o;
  assign irq_req_o  = (state == REQ);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_lvl_o <= '0;
      irq_id_o  <= '0;
      ack_src_o <= '0;
    end else begin
      state     <= next_state;
      ack_src_o <= '0;
      if (state == ARB && any_elig) begin
        irq_lvl_o <= best_lvl;
        irq_id_o  <= best_id;
      end
      if (state == REQ && ack_i) ack_src_o <= ack_onehot;
    end
  end

endmodule

// File: tb/tb_intc_irq_arb.sv
// tb/tb_intc_irq_arb.sv - directed bench for intc_irq_arb with a cycle model and literal spot checks
// The model tracks the presented request as a phase plus latched level/id, derived from the arbitration rules.
module tb_intc_irq_arb;

  localparam int NSRC = 16;
  localparam int PW   = 4;
  localparam int IW   = 5;

  logic              clk;
  logic              rst;
  logic [NSRC-1:0]   irq;
  logic [NSRC-1:0]   en;
  logic [NSRC*PW-1:0] prio;
  logic [PW-1:0]     mask;
  logic              ack;
  logic              irq_req;
  logic [PW-1:0]     irq_lvl;
  logic [IW-1:0]     irq_id;
  logic [NSRC-1:0]   ack_src;

  int vectors = 0;
  int miscompares = 0;

  intc_irq_arb #(.NSRC(NSRC), .PW(PW), .IW(IW)) dut (
    .clk(clk), .rst(rst), .irq_i(irq), .en_i(en), .prio_i(prio), .mask_i(mask),
    .ack_i(ack), .irq_req_o(irq_req), .irq_lvl_o(irq_lvl), .irq_id_o(irq_id),
    .ack_src_o(ack_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // phase: 0 waiting, 1 choosing, 2 presenting, 3 post-ack gap
  typedef struct packed {
    logic [1:0]      phase;
    logic [PW-1:0]   lvl;
    logic [IW-1:0]   id;
    logic [NSRC-1:0] acks;
  } mdl_t;

  mdl_t m;

  function automatic int pri(int k);
    return int'(prio[k*PW +: PW]);
  endfunction

  function automatic bit eligible(int k);
    return irq[k] && en[k] && (pri(k) > int'(mask));
  endfunction

  function automatic int winner();
    int top = 0;
    for (int k = 0; k < NSRC; k++) if (eligible(k) && pri(k) > top) top = pri(k);
    if (top == 0) return -1;
    for (int k = 0; k < NSRC; k++) if (eligible(k) && pri(k) == top) return k;
    return -1;
  endfunction

  function automatic mdl_t model_step(mdl_t cur);
    mdl_t nx = cur;
    int w = winner();
    nx.acks = '0;
    if (rst) return '0;
    case (cur.phase)
      2'd0: if (w >= 0) nx.phase = 2'd1;
      2'd1: begin
        if (w >= 0) begin
          nx.phase = 2'd2;
          nx.lvl   = PW'(pri(w));
          nx.id    = IW'(w);
        end else nx.phase = 2'd0;
      end
      2'd2: begin
        if (ack) begin
          nx.acks = '0;
          nx.acks[cur.id] = 1'b1;
          nx.phase = 2'd3;
        end else if (!eligible(int'(cur.id))) nx.phase = 2'd0;
        else if (w >= 0 && w != int'(cur.id) && pri(w) > int'(cur.lvl)) nx.phase = 2'd1;
      end
      default: nx.phase = 2'd0;
    endcase
    return nx;
  endfunction

  always @(posedge clk) m <= model_step(m);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("model_req", 32'(irq_req), 32'(m.phase == 2'd2));
    chk("model_lvl", 32'(irq_lvl), 32'(m.lvl));
    chk("model_id",  32'(irq_id),  32'(m.id));
    chk("model_ack", 32'(ack_src), 32'(m.acks));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_src(input int k, input int p);
    irq[k] = 1'b1;
    prio[k*PW +: PW] = PW'(p);
  endtask

  task automatic clear_all();
    irq = '0;
    prio = '0;
    mask = '0;
    ack = 1'b0;
  endtask

  task automatic lit(input string name, input logic req_e, input int lvl_e, input int id_e, input int ack_e);
    chk({name, "_req"}, 32'(irq_req), 32'(req_e));
    chk({name, "_lvl"}, 32'(irq_lvl), 32'(lvl_e));
    chk({name, "_id"},  32'(irq_id),  32'(id_e));
    chk({name, "_ack"}, 32'(ack_src), 32'(ack_e));
  endtask

  initial begin
    m = '0;
    rst = 1'b1;
    en = '1;
    clear_all();
    ticks(2);
    lit("reset", 1'b0, 0, 0, 0);
    rst = 1'b0;
    ack = 1'b1;
    ticks(2);
    lit("idle_ack_ignored", 1'b0, 0, 0, 0);
    ack = 1'b0;

    set_src(3, 5);
    tick();
    chk("single_t1_req", 32'(irq_req), 32'd0);
    tick();
    lit("single_t2", 1'b1, 5, 3, 0);
    ack = 1'b1;
    tick();
    lit("single_t3", 1'b0, 5, 3, 32'h0008);
    ack = 1'b0;
    irq = '0;
    tick();
    chk("single_t4_ack", 32'(ack_src), 32'd0);
    ticks(2);

    set_src(2, 6);
    set_src(7, 9);
    set_src(9, 9);
    ticks(2);
    lit("tie", 1'b1, 9, 7, 0);
    ack = 1'b1;
    tick();
    chk("tie_ack", 32'(ack_src), 32'h0080);
    clear_all();
    ticks(3);

    set_src(4, 4);
    mask = 4'd4;
    ticks(3);
    chk("masked_req", 32'(irq_req), 32'd0);
    mask = 4'd3;
    tick();
    chk("unmask_t1_req", 32'(irq_req), 32'd0);
    tick();
    lit("unmask_t2", 1'b1, 4, 4, 0);
    irq[4] = 1'b0;
    tick();
    lit("withdraw", 1'b0, 4, 4, 0);
    ticks(2);
    chk("withdraw_noack", 32'(ack_src), 32'd0);
    clear_all();

    set_src(1, 3);
    ticks(2);
    lit("pre_base", 1'b1, 3, 1, 0);
    set_src(5, 10);
    tick();
    chk("pre_gap_req", 32'(irq_req), 32'd0);
    tick();
    lit("pre_new", 1'b1, 10, 5, 0);
    ack = 1'b1;
    tick();
    chk("pre_new_ack", 32'(ack_src), 32'h0020);
    clear_all();
    ticks(3);

    set_src(1, 3);
    ticks(2);
    set_src(5, 10);
    ack = 1'b1;
    tick();
    lit("pre_ack_wins", 1'b0, 3, 1, 32'h0002);
    ack = 1'b0;
    ticks(3);
    lit("pre_after_gap", 1'b1, 10, 5, 0);
    clear_all();
    ticks(3);

    set_src(3, 5);
    ticks(2);
    chk("rst_mid_req", 32'(irq_req), 32'd1);
    rst = 1'b1;
    ack = 1'b1;
    tick();
    lit("rst_mid", 1'b0, 0, 0, 0);
    rst = 1'b0;
    ack = 1'b0;
    clear_all();
    tick();
    chk("rst_mid_noack", 32'(ack_src), 32'd0);
    ticks(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intc_irq_arb.md
INTC_IRQ_ARB -- requirements
Module: intc_irq_arb

Interface
REQ-001 The block SHALL have parameter NSRC, default 16, meaning the number of interrupt sources (2..32).
REQ-002 The block SHALL have parameter PW, default 4, meaning the width of each priority field and of the CPU mask.
REQ-003 The block SHALL have parameter IW, default 5, meaning the width of the source-index output (≥ clog2(NSRC)).
REQ-004 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port irq_i  input  NSRC  level interrupt lines, one per source.
REQ-007 The block SHALL have port en_i  input  NSRC  per-source enable, driven by the enable config register.
REQ-008 The block SHALL have port prio_i  input  NSRC*PW  per-source priority; source k uses bits [k*PW +: PW].
REQ-009 The block SHALL have port mask_i  input  PW  CPU interrupt mask level.
REQ-010 The block SHALL have port ack_i  input  1  CPU acknowledge; valid only while irq_req_o=1.
REQ-011 The block SHALL have port irq_req_o  output  1  interrupt request to the CPU.
REQ-012 The block SHALL have port irq_lvl_o  output  PW  priority of the presented request.
REQ-013 The block SHALL have port irq_id_o  output  IW  index of the presented source.
REQ-014 The block SHALL have port ack_src_o  output  NSRC  one-cycle, one-hot acknowledge back to the acknowledged source.

Function
REQ-015 A source k SHALL be eligible when irq_i[k]=1, en_i[k]=1 and prio(k) > mask_i; priority 0 SHALL never be eligible.
REQ-016 The arbiter SHALL select the eligible source with the highest priority; on a tie, the lowest index SHALL win.
REQ-017 The FSM SHALL have exactly four states: IDLE, ARB, REQ, GAP.
REQ-018 In IDLE, if any source is eligible, the FSM SHALL go to ARB; otherwise it SHALL stay in IDLE.
REQ-019 In ARB, the winner's priority and index SHALL be registered into irq_lvl_o/irq_id_o and the FSM SHALL go to REQ; if no source is eligible in ARB, the FSM SHALL return to IDLE.
REQ-020 irq_req_o SHALL be 1 exactly while the FSM is in REQ; the earliest assertion SHALL be 2 cycles after an eligible source appears in IDLE.
REQ-021 In REQ with ack_i=1, ack_src_o[irq_id_o] SHALL be 1 in the following cycle only, and the FSM SHALL go to GAP.
REQ-022 In REQ with ack_i=0, if the registered source is no longer eligible (line dropped, disabled or masked), the FSM SHALL go to IDLE without any ack_src_o pulse (withdrawal).
REQ-023 In REQ with ack_i=0, if a different source is eligible with a strictly higher priority than irq_lvl_o, the FSM SHALL go to ARB (preemption before acknowledge).
REQ-024 If ack_i and a withdrawal or preemption condition occur in the same REQ cycle, ack_i SHALL take precedence and the registered source SHALL be acknowledged.
REQ-025 GAP SHALL last exactly one cycle with irq_req_o=0 and SHALL then go to IDLE.
REQ-026 ack_i outside REQ SHALL be ignored.
REQ-027 irq_lvl_o and irq_id_o SHALL change only on entry to REQ or on reset, and SHALL hold their values in all other states.
REQ-028 ack_src_o SHALL be zero in every cycle except the single cycle after an accepted ack.

Reset
REQ-029 When rst=1 at a clock edge, the next state SHALL be FSM=IDLE, irq_req_o=0, irq_lvl_o=0, irq_id_o=0 and ack_src_o=0, regardless of any operation in progress, including a REQ state with ack_i=1 in the same cycle.
REQ-030 No ack_src_o pulse SHALL be generated for an ack_i sampled in the same cycle as rst=1.

Verification
REQ-031 The bench SHALL cover the single-source case: irq_i[3]=1, en_i[3]=1, prio3=5, mask=0 at cycle t -> irq_req_o=1 at t+2 with lvl=5, id=3; ack_i at t+2 -> ack_src_o=0x0008 at t+3 only; irq_req_o=0 at t+3.
REQ-032 The bench SHALL cover priority and tie-break: sources 2, 7 and 9 with priorities 6, 9 and 9 -> id=7, lvl=9.
REQ-033 The bench SHALL cover masking: prio=4 with mask=4 -> no request; changing mask to 3 -> request 2 cycles later.
REQ-034 The bench SHALL cover withdrawal: irq_i drops while in REQ without ack -> irq_req_o=0 the next cycle and no ack_src_o pulse.
REQ-035 The bench SHALL cover preemption: in REQ with id=1, lvl=3, source 5 rises with prio 10 -> irq_req_o=0 for one cycle, then REQ with id=5, lvl=10; with ack_i in that same cycle, source 1 is acknowledged instead.
REQ-036 The bench SHALL cover reset mid-operation: rst=1 during REQ with ack_i=1 -> all outputs 0 the next cycle and no ack_src_o pulse.
